// File: rtl/pc_sequencer.sv
// Microsequencer program counter, instruction fetch handshake
// and return-address stack for call/return.
module pc_sequencer #(
    parameter int             AW        = 8,
    parameter int             DW        = 16,
    parameter int             DEPTH     = 4,
    parameter logic [AW-1:0]  RESET_VEC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] pc_next_in,
    output logic [AW-1:0] pc_out,
    output logic [AW-1:0] pc_inc,
    output logic          imem_req,
    input  logic          imem_ack,
    input  logic [DW-1:0] imem_data,
    output logic [DW-1:0] ir,
    output logic          ir_valid,
    input  logic          exec_done,
    input  logic          call,
    input  logic          ret,
    output logic [AW-1:0] ret_addr,
    output logic          stk_full,
    output logic          stk_empty,
    output logic          err
);

    localparam int PW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_EXEC  = 2'd2;

    localparam logic [PW:0] SP_ONE  = (PW+1)'(1);
    localparam logic [PW:0] SP_FULL = (PW+1)'(DEPTH);

    logic [1:0]    state;
    logic [PW:0]   sp;
    logic [PW:0]   sp_m1;
    logic [AW-1:0] stk [DEPTH];

    logic step;
    logic do_push;
    logic do_pop;
    logic bad;

    assign pc_inc    = pc_out + AW'(1);
    assign imem_req  = (state == S_FETCH);
    assign stk_empty = (sp == '0);
    assign stk_full  = (sp == SP_FULL);
    assign sp_m1     = sp - SP_ONE;
    assign ret_addr  = stk_empty ? '0 : stk[sp_m1[PW-1:0]];

    // Stack moves only on a clean, in-range call or ret.
    assign step    = (state == S_EXEC) && exec_done;
    assign do_push = step && call && !ret && !stk_full;
    assign do_pop  = step && ret && !call && !stk_empty;
    assign bad     = step && ((call && ret) ||
                              (call && stk_full) ||
                              (ret && stk_empty));

    // Fetch/execute sequencing and instruction register capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            ir       <= '0;
            ir_valid <= 1'b0;
        end else begin
            ir_valid <= 1'b0;
            case (state)
                S_IDLE:  state <= S_FETCH;
                S_FETCH: begin
                    if (imem_ack) begin
                        ir       <= imem_data;
                        ir_valid <= 1'b1;
                        state    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (exec_done) state <= S_FETCH;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Program counter advances only when the datapath completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_out <= RESET_VEC;
        end else if (step) begin
            pc_out <= do_pop ? ret_addr : pc_next_in;
        end
    end

    // Return-address stack with saturating pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp <= '0;
            for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
        end else if (do_push) begin
            stk[sp[PW-1:0]] <= pc_inc;
            sp              <= sp + SP_ONE;
        end else if (do_pop) begin
            sp <= sp_m1;
        end
    end

    // Sticky misuse flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (bad) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with PC and IR scoreboards.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  pc_next_in;
    logic [7:0]  pc_out;
    logic [7:0]  pc_inc;
    logic        imem_req;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic [15:0] ir;
    logic        ir_valid;
    logic        exec_done;
    logic        call;
    logic        ret;
    logic [7:0]  ret_addr;
    logic        stk_full;
    logic        stk_empty;
    logic        err;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  pc_q [$];
    logic [15:0] ir_q [$];

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .pc_next_in(pc_next_in), .pc_out(pc_out), .pc_inc(pc_inc),
        .imem_req(imem_req), .imem_ack(imem_ack), .imem_data(imem_data),
        .ir(ir), .ir_valid(ir_valid),
        .exec_done(exec_done), .call(call), .ret(ret),
        .ret_addr(ret_addr), .stk_full(stk_full), .stk_empty(stk_empty),
        .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait for a fetch request and check its address against the scoreboard.
    task automatic wait_req();
        logic [7:0] e;
        for (int i = 0; i < 10 && !imem_req; i++) step();
        chk("req_seen", {31'b0, imem_req}, 32'd1);
        e = (pc_q.size() != 0) ? pc_q.pop_front() : 8'hxx;
        chk("fetch_pc", {24'b0, pc_out}, {24'b0, e});
    endtask

    task automatic do_fetch(input logic [15:0] d, input int waits);
        logic [15:0] e;
        logic [7:0]  p;
        wait_req();
        p = pc_out;
        for (int i = 0; i < waits; i++) begin
            step();
            chk("req_hold", {31'b0, imem_req}, 32'd1);
            chk("pc_hold", {24'b0, pc_out}, {24'b0, p});
        end
        imem_ack  = 1'b1;
        imem_data = d;
        ir_q.push_back(d);
        step();
        imem_ack  = 1'b0;
        imem_data = 16'h0;
        e = ir_q.pop_front();
        chk("ir_valid_hi", {31'b0, ir_valid}, 32'd1);
        chk("ir", {16'b0, ir}, {16'b0, e});
        chk("req_exec", {31'b0, imem_req}, 32'd0);
        step();
        chk("ir_valid_lo", {31'b0, ir_valid}, 32'd0);
    endtask

    task automatic do_exec(input logic [7:0] nxt, input logic c,
                           input logic r, input logic [7:0] exp_pc);
        pc_next_in = nxt;
        call       = c;
        ret        = r;
        exec_done  = 1'b1;
        pc_q.push_back(exp_pc);
        step();
        exec_done = 1'b0;
        call      = 1'b0;
        ret       = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_pc", {24'b0, pc_out}, 32'h00);
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_empty", {31'b0, stk_empty}, 32'd1);
        chk("rst_full", {31'b0, stk_full}, 32'd0);
        chk("rst_ret_addr", {24'b0, ret_addr}, 32'h00);
        chk("rst_ir", {16'b0, ir}, 32'h0);
        chk("rst_ir_valid", {31'b0, ir_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pc_q.delete();
        ir_q.delete();
        pc_q.push_back(8'h00);
    endtask

    initial begin
        rst_n      = 1'b0;
        pc_next_in = 8'h00;
        imem_ack   = 1'b0;
        imem_data  = 16'h0;
        exec_done  = 1'b0;
        call       = 1'b0;
        ret        = 1'b0;
        #12;
        do_reset();

        // Sequential stepping 00..03
        do_fetch(16'h1000, 0);
        do_exec(8'h01, 0, 0, 8'h01);
        do_fetch(16'h1001, 0);
        do_exec(8'h02, 0, 0, 8'h02);
        do_fetch(16'h1002, 0);
        do_exec(8'h03, 0, 0, 8'h03);
        do_fetch(16'h1003, 0);

        // Wait states at PC=10
        do_exec(8'h10, 0, 0, 8'h10);
        do_fetch(16'hABCD, 5);

        // Single call / return
        do_exec(8'h20, 0, 0, 8'h20);
        do_fetch(16'h2000, 0);
        do_exec(8'h80, 1, 0, 8'h80);
        chk("call_ret_addr", {24'b0, ret_addr}, 32'h21);
        chk("call_empty", {31'b0, stk_empty}, 32'd0);
        do_fetch(16'h8000, 0);
        do_exec(8'h85, 0, 0, 8'h85);
        do_fetch(16'h8500, 0);
        do_exec(8'h55, 0, 1, 8'h21);
        chk("ret_empty", {31'b0, stk_empty}, 32'd1);
        do_fetch(16'h2100, 0);

        // Nested calls to full, overflow, LIFO unwind
        do_exec(8'h40, 1, 0, 8'h40);
        do_fetch(16'h4000, 0);
        do_exec(8'h50, 1, 0, 8'h50);
        do_fetch(16'h5000, 0);
        do_exec(8'h60, 1, 0, 8'h60);
        do_fetch(16'h6000, 0);
        do_exec(8'h70, 1, 0, 8'h70);
        chk("nest_full", {31'b0, stk_full}, 32'd1);
        chk("nest_err0", {31'b0, err}, 32'd0);
        do_fetch(16'h7000, 0);
        do_exec(8'h90, 1, 0, 8'h90);
        chk("ovf_err", {31'b0, err}, 32'd1);
        chk("ovf_full", {31'b0, stk_full}, 32'd1);
        chk("ovf_top", {24'b0, ret_addr}, 32'h61);
        do_fetch(16'h9000, 0);
        do_exec(8'h00, 0, 1, 8'h61);
        chk("pop1_top", {24'b0, ret_addr}, 32'h51);
        do_fetch(16'h6100, 0);
        do_exec(8'h00, 0, 1, 8'h51);
        chk("pop2_top", {24'b0, ret_addr}, 32'h41);
        do_fetch(16'h5100, 0);
        do_exec(8'h00, 0, 1, 8'h41);
        chk("pop3_top", {24'b0, ret_addr}, 32'h22);
        do_fetch(16'h4100, 0);
        do_exec(8'h00, 0, 1, 8'h22);
        chk("pop4_empty", {31'b0, stk_empty}, 32'd1);
        do_fetch(16'h2200, 0);

        // Ret on empty stack
        do_reset();
        do_fetch(16'h0000, 0);
        do_exec(8'h33, 0, 1, 8'h33);
        chk("udf_err", {31'b0, err}, 32'd1);
        chk("udf_empty", {31'b0, stk_empty}, 32'd1);
        do_fetch(16'h3300, 0);

        // Call and ret together
        do_reset();
        do_fetch(16'h0000, 0);
        do_exec(8'h30, 1, 0, 8'h30);
        do_fetch(16'h3000, 0);
        chk("cr_err0", {31'b0, err}, 32'd0);
        do_exec(8'h44, 1, 1, 8'h44);
        chk("cr_err", {31'b0, err}, 32'd1);
        chk("cr_top", {24'b0, ret_addr}, 32'h01);
        chk("cr_empty", {31'b0, stk_empty}, 32'd0);
        chk("cr_full", {31'b0, stk_full}, 32'd0);
        do_fetch(16'h4400, 0);

        // Ack during EXEC is ignored
        imem_ack  = 1'b1;
        imem_data = 16'hDEAD;
        step();
        imem_ack  = 1'b0;
        chk("ack_exec_ir", {16'b0, ir}, 32'h4400);
        chk("ack_exec_req", {31'b0, imem_req}, 32'd0);

        // PC wrap and async reset mid-FETCH
        do_exec(8'hFF, 0, 0, 8'hFF);
        wait_req();
        chk("wrap_inc", {24'b0, pc_inc}, 32'h00);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req", {31'b0, imem_req}, 32'd0);
        chk("arst_pc", {24'b0, pc_out}, 32'h00);
        imem_ack  = 1'b1;
        imem_data = 16'hBEEF;
        step();
        imem_ack  = 1'b0;
        chk("arst_ir", {16'b0, ir}, 32'h0);
        chk("arst_ir_valid", {31'b0, ir_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
